pc_sequencer: RTL

- Multicycle control FSM for the 16-bit processor. It fetches each instruction, decodes it and drives the program-counter control pulses (increment, displace, jal, replace, unconditional).
- It also drives register-file write, flag write, memory write and address select, and supplies the sign-extended branch displacement to the PC block.
- It sits between the instruction/data RAM, the PSR flag register and the PC counter.
- Every instruction produces exactly one PC-control pulse.

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/cond_eval.sv | 42 ++++
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 16-bit processor control path: FSM state codes,
// instruction field encodings, branch condition codes and write-back selects.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_LINK   = 3'd5;

  localparam logic [3:0] OP_MEMJ  = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes; flags are ordered {N,Z,F,L,C}.
  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_CS    = 4'b0010;
  localparam logic [3:0] COND_CC    = 4'b0011;
  localparam logic [3:0] COND_L     = 4'b0100;
  localparam logic [3:0] COND_NL    = 4'b0101;
  localparam logic [3:0] COND_N     = 4'b0110;
  localparam logic [3:0] COND_NN    = 4'b0111;
  localparam logic [3:0] COND_F     = 4'b1000;
  localparam logic [3:0] COND_NF    = 4'b1001;
  localparam logic [3:0] COND_NL_NZ = 4'b1010;
  localparam logic [3:0] COND_L_Z   = 4'b1011;
  localparam logic [3:0] COND_NN_NZ = 4'b1100;
  localparam logic [3:0] COND_N_Z   = 4'b1101;
  localparam logic [3:0] COND_AL    = 4'b1110;
  localparam logic [3:0] COND_NV    = 4'b1111;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the PSR flags
// to a single take/not-take decision.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       take
);

  logic w_n, w_z, w_f, w_l, w_c;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_f = flags[FLAG_F];
  assign w_l = flags[FLAG_L];
  assign w_c = flags[FLAG_C];

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ:    take = w_z;
      COND_NE:    take = !w_z;
      COND_CS:    take = w_c;
      COND_CC:    take = !w_c;
      COND_L:     take = w_l;
      COND_NL:    take = !w_l;
      COND_N:     take = w_n;
      COND_NN:    take = !w_n;
      COND_F:     take = w_f;
      COND_NF:    take = !w_f;
      COND_NL_NZ: take = !w_l && !w_z;
      COND_L_Z:   take = w_l || w_z;
      COND_NN_NZ: take = !w_n && !w_z;
      COND_N_Z:   take = w_n || w_z;
      COND_AL:    take = 1'b1;
      COND_NV:    take = 1'b0;
      default:    take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute controller. Drives exactly one PC-control
// pulse per instruction plus register-file, PSR and RAM control strobes.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [4:0]       flags,
  output logic [WIDTH-1:0] ir,
  output logic             increment,
  output logic             displace,
  output logic             jal,
  output logic             replace,
  output logic             unconditional,
  output logic [WIDTH-1:0] imm_ext,
  output logic             regwrite,
  output logic [1:0]       wb_sel,
  output logic             flag_we,
  output logic             memwrite,
  output logic             addr_sel,
  output logic [2:0]       state_dbg
);

  if (WIDTH != 16) begin : g_width_check
    $error("pc_sequencer supports WIDTH=16 only");
  end

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_ir;

  logic [2:0] w_next;
  logic [2:0] w_resume;
  logic [3:0] w_op, w_cond, w_ext;
  logic       w_take;
  logic       w_inc, w_disp, w_jal, w_repl, w_unc;
  logic       w_regwrite, w_flag_we, w_memwrite, w_addr_sel;
  logic [1:0] w_wb_sel;

  assign w_op   = r_ir[15:12];
  assign w_cond = r_ir[11:8];
  assign w_ext  = r_ir[7:4];

  // Dropping run only takes effect where the FSM would otherwise refetch.
  assign w_resume = (run || AUTO_RUN) ? ST_FETCH : ST_IDLE;

  cond_eval u_cond_eval (
    .cond  (w_cond),
    .flags (flags),
    .take  (w_take)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_inc      = 1'b0;
    w_disp     = 1'b0;
    w_jal      = 1'b0;
    w_repl     = 1'b0;
    w_unc      = 1'b0;
    w_regwrite = 1'b0;
    w_wb_sel   = WB_ALU;
    w_flag_we  = 1'b0;
    w_memwrite = 1'b0;
    w_addr_sel = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run || AUTO_RUN) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_addr_sel = 1'b0;
        w_next     = ST_DECODE;
      end
      ST_DECODE: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_op == OP_MEMJ && w_ext == EXT_LOAD) begin
          w_addr_sel = 1'b1;
          w_next     = ST_MEM;
        end else if (w_op == OP_MEMJ && w_ext == EXT_STOR) begin
          w_addr_sel = 1'b1;
          w_memwrite = 1'b1;
          w_inc      = 1'b1;
          w_next     = w_resume;
        end else if (w_op == OP_MEMJ && w_ext == EXT_JAL) begin
          w_jal  = 1'b1;
          w_next = ST_LINK;
        end else if (w_op == OP_MEMJ && w_ext == EXT_JCOND) begin
          if (w_cond == COND_AL) w_unc = 1'b1;
          else if (w_take)       w_repl = 1'b1;
          else                   w_inc = 1'b1;
          w_next = w_resume;
        end else if (w_op == OP_BCOND) begin
          if (w_take) w_disp = 1'b1;
          else        w_inc = 1'b1;
          w_next = w_resume;
        end else begin
          // Everything else, including unused MEMJ ext codes, is an ALU op.
          w_regwrite = 1'b1;
          w_wb_sel   = WB_ALU;
          w_flag_we  = 1'b1;
          w_inc      = 1'b1;
          w_next     = w_resume;
        end
      end
      ST_MEM: begin
        w_regwrite = 1'b1;
        w_wb_sel   = WB_MEM;
        w_inc      = 1'b1;
        w_next     = w_resume;
      end
      ST_LINK: begin
        // The PC block captured oldpc on the JAL edge; write it back now.
        w_regwrite = 1'b1;
        w_wb_sel   = WB_LINK;
        w_next     = w_resume;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Reset low blanks every output in the same cycle, before the clock edge.
  assign ir            = rst ? r_ir : '0;
  assign imm_ext       = rst ? {{8{r_ir[7]}}, r_ir[7:0]} : '0;
  assign state_dbg     = rst ? r_state : 3'd0;
  assign increment     = rst & w_inc;
  assign displace      = rst & w_disp;
  assign jal           = rst & w_jal;
  assign replace       = rst & w_repl;
  assign unconditional = rst & w_unc;
  assign regwrite      = rst & w_regwrite;
  assign wb_sel        = rst ? w_wb_sel : 2'd0;
  assign flag_we       = rst & w_flag_we;
  assign memwrite      = rst & w_memwrite;
  assign addr_sel      = rst & w_addr_sel;

endmodule
